// File: rtl/hcsr04_seq_pkg.sv
// Shared constants for the HC-SR04 sequencer: state codes and the 50 MHz timing defaults.
package hcsr04_seq_pkg;

  localparam logic [3:0] ST_INICIAL       = 4'd0;
  localparam logic [3:0] ST_PREPARACAO    = 4'd1;
  localparam logic [3:0] ST_ENVIA_TRIGGER = 4'd2;
  localparam logic [3:0] ST_ESPERA_ECHO   = 4'd3;
  localparam logic [3:0] ST_MEDINDO       = 4'd4;
  localparam logic [3:0] ST_ARMAZENA      = 4'd5;
  localparam logic [3:0] ST_FINAL         = 4'd6;
  localparam logic [3:0] ST_ERRO          = 4'd7;

  // 10 us trigger and 30 ms echo budget at 50 MHz
  localparam int TRIG_CYCLES_DEF    = 500;
  localparam int TIMEOUT_CYCLES_DEF = 1_500_000;
  localparam int TIMER_W_DEF        = 22;

endpackage

// File: rtl/seq_timer.sv
// Up-counter with synchronous clear and enable; fim flags count == limite.
module seq_timer #(
  parameter int TIMER_W = 22
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               zera,
  input  logic               conta,
  input  logic [TIMER_W-1:0] limite,
  output logic               fim
);

  logic [TIMER_W-1:0] contagem_reg;

  // zera has priority so the FSM can clear on the same cycle it stops counting
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem_reg <= '0;
    end else if (zera) begin
      contagem_reg <= '0;
    end else if (conta) begin
      contagem_reg <= contagem_reg + 1'b1;
    end
  end

  assign fim = (contagem_reg == limite);

endmodule

// File: rtl/hcsr04_seq.sv
// HC-SR04 measurement sequencer: trigger pulse, echo wait, BCD distance latch.
// Define HCSR04_SEQ_TIMEOUT_EN to enable the echo timeout and the erro state.
module hcsr04_seq
  import hcsr04_seq_pkg::*;
#(
  parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TIMER_W        = TIMER_W_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  input  logic        fim_cm,
  input  logic [11:0] distancia_bcd,
  output logic        trigger,
  output logic        zera_cm,
  output logic        echo_sinc,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        timeout,
  output logic [3:0]  db_estado
);

  logic [3:0]         estado_reg;
  logic [3:0]         estado_next;
  logic [1:0]         echo_sync_reg;
  logic               timer_zera;
  logic               timer_conta;
  logic               timer_fim;
  logic               estouro;
  logic [TIMER_W-1:0] timer_limite;

  // echo is asynchronous to clock: two-flop synchronizer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_sync_reg <= 2'b00;
    end else begin
      echo_sync_reg <= {echo_sync_reg[0], echo};
    end
  end

  assign echo_sinc = echo_sync_reg[1];

  assign timer_limite = (estado_reg == ST_ENVIA_TRIGGER) ? TIMER_W'(TRIG_CYCLES - 1)
                                                         : TIMER_W'(TIMEOUT_CYCLES - 1);
  assign timer_zera   = (estado_reg == ST_PREPARACAO) ||
                        ((estado_reg == ST_ENVIA_TRIGGER) && timer_fim);

`ifdef HCSR04_SEQ_TIMEOUT_EN
  // one shared budget across espera_echo and medindo
  assign timer_conta = (estado_reg == ST_ENVIA_TRIGGER) ||
                       (estado_reg == ST_ESPERA_ECHO)   ||
                       (estado_reg == ST_MEDINDO);
  assign estouro     = timer_fim;
`else
  assign timer_conta = (estado_reg == ST_ENVIA_TRIGGER);
  assign estouro     = 1'b0;
`endif

  seq_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .zera   (timer_zera),
    .conta  (timer_conta),
    .limite (timer_limite),
    .fim    (timer_fim)
  );

  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      ST_INICIAL:       if (medir) estado_next = ST_PREPARACAO;
      ST_PREPARACAO:    estado_next = ST_ENVIA_TRIGGER;
      ST_ENVIA_TRIGGER: if (timer_fim) estado_next = ST_ESPERA_ECHO;
      ST_ESPERA_ECHO: begin
        if (echo_sinc)    estado_next = ST_MEDINDO;
        else if (estouro) estado_next = ST_ERRO;
      end
      // a result arriving on the timeout edge is still accepted
      ST_MEDINDO: begin
        if (fim_cm)       estado_next = ST_ARMAZENA;
        else if (estouro) estado_next = ST_ERRO;
      end
      ST_ARMAZENA:      estado_next = ST_FINAL;
      ST_FINAL:         estado_next = ST_INICIAL;
      ST_ERRO:          estado_next = ST_INICIAL;
      default:          estado_next = ST_INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_reg <= ST_INICIAL;
    end else begin
      estado_reg <= estado_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      medida <= 12'h000;
    end else if (estado_reg == ST_ARMAZENA) begin
      medida <= distancia_bcd;
    end
  end

  assign zera_cm   = (estado_reg == ST_PREPARACAO);
  assign trigger   = (estado_reg == ST_ENVIA_TRIGGER);
  assign pronto    = (estado_reg == ST_FINAL);
  assign db_estado = estado_reg;
`ifdef HCSR04_SEQ_TIMEOUT_EN
  assign timeout   = (estado_reg == ST_ERRO);
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_hcsr04_seq.sv
// Scoreboard bench for hcsr04_seq with TRIG_CYCLES=5, TIMEOUT_CYCLES=100.
// Timeout expectations follow HCSR04_SEQ_TIMEOUT_EN, matching the DUT build.
module tb_hcsr04_seq;

  localparam int TRIG    = 5;
  localparam int TIMEOUT = 100;

  logic        clock = 1'b0;
  logic        reset;
  logic        medir;
  logic        echo;
  logic        fim_cm;
  logic [11:0] distancia_bcd;
  logic        trigger;
  logic        zera_cm;
  logic        echo_sinc;
  logic [11:0] medida;
  logic        pronto;
  logic        timeout;
  logic [3:0]  db_estado;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pronto = 0;
  int n_timeout = 0;
  logic [11:0] sb_q[$];

  hcsr04_seq #(
    .TRIG_CYCLES    (TRIG),
    .TIMEOUT_CYCLES (TIMEOUT),
    .TIMER_W        (22)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .medir         (medir),
    .echo          (echo),
    .fim_cm        (fim_cm),
    .distancia_bcd (distancia_bcd),
    .trigger       (trigger),
    .zera_cm       (zera_cm),
    .echo_sinc     (echo_sinc),
    .medida        (medida),
    .pronto        (pronto),
    .timeout       (timeout),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
    n_checks++;
    if (obtido === esperado) n_pass++;
    else $display("FAIL %s: obtido=%0h esperado=%0h", tag, obtido, esperado);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic espera_estado(input logic [3:0] alvo, input int limite, input string tag);
    int n = 0;
    while (db_estado !== alvo && n < limite) begin
      tick();
      n++;
    end
    check(tag, 32'(db_estado), 32'(alvo));
  endtask

  // From inicial through the trigger pulse; returns in the first espera_echo cycle.
  task automatic inicia(input bit manter);
    int n = 0;
    medir = 1'b1;
    tick();
    if (!manter) medir = 1'b0;
    check("zera_cm_on", 32'(zera_cm), 1);
    check("trig_antes", 32'(trigger), 0);
    check("est_prep", 32'(db_estado), 1);
    tick();
    check("zera_cm_1ciclo", 32'(zera_cm), 0);
    while (trigger === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    check("trig_largura", n, TRIG);
    check("est_espera", 32'(db_estado), 3);
  endtask

  // From medindo: drive fim_cm, expect armazena -> final with medida = bcd.
  task automatic termina(input logic [11:0] bcd);
    repeat (10) tick();
    fim_cm = 1'b1;
    distancia_bcd = bcd;
    sb_q.push_back(bcd);
    tick();
    fim_cm = 1'b0;
    echo = 1'b0;
    check("est_armazena", 32'(db_estado), 5);
    tick();
    check("pronto_on", 32'(pronto), 1);
    check("medida", 32'(medida), 32'(bcd));
    tick();
    check("pronto_1ciclo", 32'(pronto), 0);
    check("est_volta", 32'(db_estado), 0);
  endtask

  task automatic medicao(input logic [11:0] bcd, input bit manter);
    inicia(manter);
    repeat (20) tick();
    echo = 1'b1;
    espera_estado(4'd4, 10, "est_medindo");
    check("echo_sinc", 32'(echo_sinc), 1);
    termina(bcd);
  endtask

  // Scoreboard side: every pronto pulse must carry the next expected distance.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (pronto === 1'b1) begin
        n_pronto++;
        if (sb_q.size() == 0) check("sb_vazio", sb_q.size(), 1);
        else begin
          $display("transacao pronto medida=%03h", medida);
          check("sb_medida", 32'(medida), 32'(sb_q.pop_front()));
        end
      end
      if (timeout === 1'b1) begin
        n_timeout++;
        $display("transacao timeout medida=%03h", medida);
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: obtido=tempo esgotado esperado=fim");
    $fatal(1);
  end

  initial begin
    int n;
    bit viu_trig;
    int esperado_pronto;
    int esperado_timeout;
    reset = 1'b1;
    medir = 1'b0;
    echo = 1'b0;
    fim_cm = 1'b0;
    distancia_bcd = 12'h000;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset / idle
    check("rst_trigger", 32'(trigger), 0);
    check("rst_zera", 32'(zera_cm), 0);
    check("rst_pronto", 32'(pronto), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_estado", 32'(db_estado), 0);
    check("rst_medida", 32'(medida), 0);
    check("rst_echo_sinc", 32'(echo_sinc), 0);

    // normal measurement
    medicao(12'h123, 1'b0);

    // echo never rises
    inicia(1'b0);
    n = 0;
    viu_trig = 1'b0;
`ifdef HCSR04_SEQ_TIMEOUT_EN
    while (db_estado !== 4'd7 && n < 300) begin
      tick();
      n++;
      if (trigger === 1'b1) viu_trig = 1'b1;
    end
    check("timeout_latencia", n, TIMEOUT);
    check("timeout_on", 32'(timeout), 1);
    check("timeout_medida", 32'(medida), 32'h123);
    check("timeout_sem_trig", 32'(viu_trig), 0);
    tick();
    check("timeout_1ciclo", 32'(timeout), 0);
    check("timeout_volta", 32'(db_estado), 0);
`else
    while (n < 300) begin
      tick();
      n++;
      if (trigger === 1'b1) viu_trig = 1'b1;
    end
    check("sem_timeout_estado", 32'(db_estado), 3);
    check("sem_timeout_pino", 32'(timeout), 0);
    check("sem_timeout_medida", 32'(medida), 32'h123);
    check("sem_timeout_trig", 32'(viu_trig), 0);
    echo = 1'b1;
    espera_estado(4'd4, 10, "est_medindo_tardio");
    termina(12'h123);
`endif

    // fim_cm on the same edge as the timeout
    inicia(1'b0);
    echo = 1'b1;
    repeat (TIMEOUT - 1) tick();
    check("colisao_medindo", 32'(db_estado), 4);
    fim_cm = 1'b1;
    distancia_bcd = 12'h456;
    sb_q.push_back(12'h456);
    tick();
    fim_cm = 1'b0;
    echo = 1'b0;
    check("colisao_armazena", 32'(db_estado), 5);
    check("colisao_timeout", 32'(timeout), 0);
    tick();
    check("colisao_pronto", 32'(pronto), 1);
    check("colisao_medida", 32'(medida), 32'h456);
    tick();

    // asynchronous reset mid-trigger
    medir = 1'b1;
    tick();
    medir = 1'b0;
    tick();
    tick();
    check("pre_reset_trig", 32'(trigger), 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_trig", 32'(trigger), 0);
    check("rst_async_estado", 32'(db_estado), 0);
    check("rst_async_medida", 32'(medida), 0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("pos_reset_estado", 32'(db_estado), 0);

    // medir held high: back-to-back measurements
    medir = 1'b1;
    medicao(12'h045, 1'b1);
    medicao(12'h210, 1'b0);
    tick();
    check("fim_ocioso", 32'(db_estado), 0);
    check("medida_final", 32'(medida), 32'h210);

`ifdef HCSR04_SEQ_TIMEOUT_EN
    esperado_pronto = 4;
    esperado_timeout = 1;
`else
    esperado_pronto = 5;
    esperado_timeout = 0;
`endif
    check("n_pronto", n_pronto, esperado_pronto);
    check("n_timeout", n_timeout, esperado_timeout);
    check("sb_restante", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
